// File: rtl/mul_unit_if.sv
// mul_unit_if: issue and writeback bundle between decode, the multiplier and the writeback arbiter.
interface mul_unit_if #(
  parameter int REG_ADDRESS_SIZE = 5,
  parameter int REG_SIZE = 32
);
  logic                        MUL_valid;
  logic [REG_SIZE-1:0]         MUL_operand1;
  logic [REG_SIZE-1:0]         MUL_operand2;
  logic [REG_ADDRESS_SIZE-1:0] MUL_dest;
  logic                        MUL_w;
  logic                        MUL_stall;
  logic                        MUL_We;
  logic [REG_ADDRESS_SIZE-1:0] MUL_Wat;
  logic [REG_SIZE-1:0]         MUL_Wvalue;
  logic                        MUL_Wack;
  modport master (
    output MUL_valid, MUL_operand1, MUL_operand2, MUL_dest, MUL_w, MUL_Wack,
    input  MUL_stall, MUL_We, MUL_Wat, MUL_Wvalue
  );
  modport slave (
    input  MUL_valid, MUL_operand1, MUL_operand2, MUL_dest, MUL_w, MUL_Wack,
    output MUL_stall, MUL_We, MUL_Wat, MUL_Wvalue
  );
endinterface

// File: rtl/mul_unit.sv
// mul_unit: iterative shift-add multiplier, one multiplier bit per cycle, low REG_SIZE bits of the product.
module mul_unit #(
  parameter int REG_ADDRESS_SIZE = 5,
  parameter int REG_SIZE = 32
) (
  input logic     clk,
  input logic     reset,
  mul_unit_if.slave m
);
  localparam int CW = $clog2(REG_SIZE);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [REG_SIZE-1:0]         acc_q, acc_d, op1_q, op1_d, op2_q, op2_d;
  logic [REG_ADDRESS_SIZE-1:0] dest_q, dest_d;
  logic                        w_q, w_d;
  logic                        busy, accept, last;
  assign busy        = state_q == BUSY;
  assign m.MUL_stall = busy || (state_q == DONE && !m.MUL_Wack);
  assign accept      = m.MUL_valid && !m.MUL_stall;
  assign last        = cnt_q == CW'(REG_SIZE - 1);
  assign m.MUL_We     = state_q == DONE;
  assign m.MUL_Wat    = dest_q;
  assign m.MUL_Wvalue = acc_q;
  always_comb begin
    state_d = accept ? BUSY
            : busy ? (last ? (w_q ? DONE : IDLE) : BUSY)
            : (state_q == DONE && m.MUL_Wack) ? IDLE : state_q;
    op1_d  = accept ? m.MUL_operand1 : op1_q;
    op2_d  = accept ? m.MUL_operand2 : op2_q;
    dest_d = accept ? m.MUL_dest : dest_q;
    w_d    = accept ? m.MUL_w : w_q;
    cnt_d  = accept ? '0 : busy ? cnt_q + 1'b1 : cnt_q;
    // truncating add keeps the low product bits, identical for signed and unsigned operands
    acc_d  = accept ? '0 : (busy && op2_q[cnt_q]) ? acc_q + (op1_q << cnt_q) : acc_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      dest_q  <= '0;
      w_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      dest_q  <= dest_d;
      w_q     <= w_d;
    end
  end
endmodule

// File: doc/mul_unit.md
MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 Parameter REG_ADDRESS_SIZE, 5, register address width.
REQ-002 Parameter REG_SIZE, 32, operand and result width; also the iteration count.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; low forces reset state immediately, independent of clk.
REQ-005 MUL_valid  input  1  decode stage issues a multiply this cycle.
REQ-006 MUL_operand1  input  REG_SIZE  multiplicand.
REQ-007 MUL_operand2  input  REG_SIZE  multiplier (register value or immediate).
REQ-008 MUL_dest  input  REG_ADDRESS_SIZE  destination register.
REQ-009 MUL_w  input  1  instruction writes the register file.
REQ-010 MUL_stall  output  1  unit cannot accept an issue this cycle.
REQ-011 MUL_We  output  1  writeback request valid.
REQ-012 MUL_Wat  output  REG_ADDRESS_SIZE  writeback destination.
REQ-013 MUL_Wvalue  output  REG_SIZE  writeback data.
REQ-014 MUL_Wack  input  1  writeback arbiter accepts the request this cycle.

Function
REQ-015 The issue SHALL be accepted on a rising edge where MUL_valid=1 and MUL_stall=0; otherwise inputs SHALL be ignored and not captured.
REQ-016 On acceptance, the unit SHALL latch operand1, operand2, dest and w, clear the accumulator and iteration counter, and enter BUSY.
REQ-017 States SHALL be IDLE, BUSY and DONE.
REQ-018 In BUSY, each edge SHALL add (operand1 << i) to the accumulator when operand2 bit i=1, for i = counter value, and increment the counter.
REQ-019 The add SHALL truncate to REG_SIZE bits, so the result equals the low REG_SIZE bits of the product; this holds for both signed and unsigned operands.
REQ-020 After the edge processing bit REG_SIZE-1, the unit SHALL go to DONE if the latched w=1, otherwise to IDLE.
REQ-021 Latency: for acceptance in cycle t, BUSY SHALL span cycles t+1..t+REG_SIZE, and MUL_We SHALL first be high in cycle t+REG_SIZE+1.
REQ-022 In DONE, MUL_We SHALL be 1, and MUL_Wat/MUL_Wvalue SHALL hold stable until a cycle with MUL_Wack=1.
REQ-023 DONE with MUL_Wack=1 SHALL transition to IDLE, or to BUSY if a new issue is accepted the same edge.
REQ-024 MUL_stall = (state==BUSY) OR (state==DONE AND MUL_Wack=0); it is combinational, so back-to-back issue is possible on the ack cycle.
REQ-025 MUL_We SHALL be 0 in IDLE and BUSY.
REQ-026 MUL_Wack outside DONE SHALL be ignored.
REQ-027 MUL_dest=0 SHALL be processed normally; discarding r0 writes is the register bank's responsibility.
REQ-028 Operand values SHALL NOT shorten latency; zero operands take the full REG_SIZE cycles.

Reset
REQ-029 While reset=0: state IDLE, counter 0, accumulator 0, latched fields 0.
REQ-030 While reset=0: MUL_stall=0, MUL_We=0, MUL_Wat=0, MUL_Wvalue=0.
REQ-031 Reset asserted mid-BUSY or mid-DONE SHALL discard the in-flight operation with no writeback.
REQ-032 After reset release, the first rising edge SHALL accept an issue normally.

Verification
REQ-033 Issue 7*6, w=1, dest=3 in cycle t -> MUL_stall=1 in cycles t+1..t+32; cycle t+33: MUL_We=1, MUL_Wat=3, MUL_Wvalue=42.
REQ-034 Issue 0xFFFFFFFF*0xFFFFFFFF -> MUL_Wvalue=0x00000001. Issue 0x80000000*2 -> MUL_Wvalue=0x00000000.
REQ-035 In DONE, hold MUL_Wack=0 for 5 cycles -> MUL_We, MUL_Wat and MUL_Wvalue stable and MUL_stall=1 throughout; then MUL_Wack=1 -> MUL_stall=0 that cycle and MUL_We=0 next cycle.
REQ-036 In DONE, assert MUL_Wack=1 and MUL_valid=1 (3*5, dest=9) in the same cycle -> new op accepted; MUL_We=0 for 32 cycles, then MUL_We=1, MUL_Wat=9, MUL_Wvalue=15.
REQ-037 Issue with w=0 -> MUL_We never asserted; MUL_stall=0 in cycle t+33.
REQ-038 Drive reset=0 in BUSY cycle 10 -> all outputs 0 immediately, no MUL_We ever for that op; after release, 3*5 yields 15.
